// File: rtl/vga_note_sched.sv
// Note-display sequencer: full-screen clears, slot erase, glyph engine kick-off and pixel forwarding.
// Optional draw watchdog enabled by defining VGA_NOTE_SCHED_TIMEOUT_EN.
module vga_note_sched #(
  parameter int X0         = 8,
  parameter int Y0         = 20,
  parameter int SLOT_PITCH = 40,
  parameter int REGION_W   = 36,
  parameter int REGION_H   = 12
`ifdef VGA_NOTE_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  input  logic [1:0] slot_in,
  input  logic       clr_req,
  output logic       draw_start,
  output logic [3:0] draw_note,
  output logic [1:0] draw_octave,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  input  logic       draw_done,
  input  logic [7:0] eng_x,
  input  logic [6:0] eng_y,
  input  logic [2:0] eng_colour,
  input  logic       eng_we,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       writeEn,
`ifdef VGA_NOTE_SCHED_TIMEOUT_EN
  output logic       draw_timeout,
`endif
  output logic       busy
);

  typedef enum logic [2:0] {INIT_CLEAR, IDLE, FULL_CLEAR, ERASE, DRAW_START, DRAW_WAIT} state_t;

  localparam logic [6:0] OY   = 7'(Y0);
  localparam logic [7:0] W_LM = 8'(REGION_W - 1);
  localparam logic [6:0] H_LM = 7'(REGION_H - 1);

  state_t     state;
  logic [7:0] cx;
  logic [6:0] cy;
  logic       pend_clr;
  logic       ready_q;
  logic [3:0] note_q;
  logic [1:0] oct_q;
  logic [1:0] slot_q;
  logic       accept;
`ifdef VGA_NOTE_SCHED_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYC+1)-1:0] tcnt;
`endif

  function automatic logic [7:0] origin(input logic [1:0] s);
    return 8'(X0 + int'(s) * SLOT_PITCH);
  endfunction

  // ready_q is the registered IDLE/no-pending-clear term; a same-cycle clr_req
  // must still block acceptance because the clear wins.
  assign note_ready = ready_q & ~clr_req;
  assign accept     = note_valid & note_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= INIT_CLEAR;
      cx          <= '0;
      cy          <= '0;
      pend_clr    <= 1'b0;
      ready_q     <= 1'b0;
      note_q      <= '0;
      oct_q       <= '0;
      slot_q      <= '0;
      draw_start  <= 1'b0;
      draw_note   <= '0;
      draw_octave <= '0;
      draw_x      <= '0;
      draw_y      <= '0;
      x_out       <= '0;
      y_out       <= '0;
      colour      <= '0;
      writeEn     <= 1'b0;
      busy        <= 1'b0;
`ifdef VGA_NOTE_SCHED_TIMEOUT_EN
      tcnt         <= '0;
      draw_timeout <= 1'b0;
`endif
    end else begin
      draw_start <= 1'b0;
      case (state)
        INIT_CLEAR, FULL_CLEAR: begin
          writeEn <= 1'b1;
          colour  <= 3'b000;
          x_out   <= cx;
          y_out   <= cy;
          busy    <= 1'b1;
          ready_q <= 1'b0;
          if (cx == 8'd159) begin
            cx <= '0;
            if (cy == 7'd119) begin
              cy      <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
              ready_q <= 1'b1;
            end else cy <= cy + 7'd1;
          end else cx <= cx + 8'd1;
        end
        IDLE: begin
          writeEn <= 1'b0;
          if (clr_req || pend_clr) begin
            state    <= FULL_CLEAR;
            pend_clr <= 1'b0;
            cx       <= '0;
            cy       <= '0;
            busy     <= 1'b1;
            ready_q  <= 1'b0;
          end else if (accept) begin
            // Pixel (0,0) of the erase goes out on this edge; counters point at the next one.
            note_q  <= note_in;
            oct_q   <= octave_in;
            slot_q  <= slot_in;
            x_out   <= origin(slot_in);
            y_out   <= OY;
            colour  <= 3'b000;
            writeEn <= 1'b1;
            cx      <= 8'd1;
            cy      <= '0;
            state   <= ERASE;
            busy    <= 1'b1;
            ready_q <= 1'b0;
`ifdef VGA_NOTE_SCHED_TIMEOUT_EN
            draw_timeout <= 1'b0;
`endif
          end else begin
            busy    <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        ERASE: begin
          if (clr_req) pend_clr <= 1'b1;
          writeEn <= 1'b1;
          colour  <= 3'b000;
          x_out   <= origin(slot_q) + cx;
          y_out   <= OY + cy;
          if (cx == W_LM) begin
            cx <= '0;
            if (cy == H_LM) begin
              cy <= '0;
              if (note_q == 4'd0) begin
                state   <= IDLE;
                busy    <= 1'b0;
                ready_q <= !(pend_clr || clr_req);
              end else state <= DRAW_START;
            end else cy <= cy + 7'd1;
          end else cx <= cx + 8'd1;
        end
        DRAW_START: begin
          if (clr_req) pend_clr <= 1'b1;
          writeEn     <= 1'b0;
          draw_start  <= 1'b1;
          draw_note   <= note_q;
          draw_octave <= oct_q;
          draw_x      <= origin(slot_q);
          draw_y      <= OY;
          state       <= DRAW_WAIT;
`ifdef VGA_NOTE_SCHED_TIMEOUT_EN
          tcnt        <= '0;
`endif
        end
        DRAW_WAIT: begin
          if (clr_req) pend_clr <= 1'b1;
          x_out   <= eng_x;
          y_out   <= eng_y;
          colour  <= eng_colour;
          writeEn <= eng_we;
          if (draw_done) begin
            state   <= IDLE;
            writeEn <= 1'b0;
            busy    <= 1'b0;
            ready_q <= !(pend_clr || clr_req);
          end
`ifdef VGA_NOTE_SCHED_TIMEOUT_EN
          else if (tcnt == ($bits(tcnt))'(TIMEOUT_CYC - 1)) begin
            state        <= IDLE;
            writeEn      <= 1'b0;
            busy         <= 1'b0;
            ready_q      <= !(pend_clr || clr_req);
            draw_timeout <= 1'b1;
          end else tcnt <= tcnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_note_sched.sv
// Randomized directed bench for vga_note_sched; expected pixel streams are built from
// the raster/erase geometry and the engine stimulus, then compared against captured writes.
module tb_vga_note_sched;
  logic       clk = 1'b0, resetn = 1'b1;
  logic       note_valid = 1'b0, clr_req = 1'b0, draw_done = 1'b0, eng_we = 1'b0;
  logic [3:0] note_in = '0;
  logic [1:0] octave_in = '0, slot_in = '0;
  logic [7:0] eng_x = '0;
  logic [6:0] eng_y = '0;
  logic [2:0] eng_colour = '0;
  logic       note_ready, draw_start, writeEn, busy;
  logic [3:0] draw_note;
  logic [1:0] draw_octave;
  logic [7:0] draw_x, x_out;
  logic [6:0] draw_y, y_out;
  logic [2:0] colour;
`ifdef VGA_NOTE_SCHED_TIMEOUT_EN
  logic       draw_timeout;
`endif

  vga_note_sched dut (
    .clk(clk), .resetn(resetn), .note_valid(note_valid), .note_ready(note_ready),
    .note_in(note_in), .octave_in(octave_in), .slot_in(slot_in), .clr_req(clr_req),
    .draw_start(draw_start), .draw_note(draw_note), .draw_octave(draw_octave),
    .draw_x(draw_x), .draw_y(draw_y), .draw_done(draw_done), .eng_x(eng_x),
    .eng_y(eng_y), .eng_colour(eng_colour), .eng_we(eng_we), .x_out(x_out),
    .y_out(y_out), .colour(colour), .writeEn(writeEn),
`ifdef VGA_NOTE_SCHED_TIMEOUT_EN
    .draw_timeout(draw_timeout),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  typedef logic [17:0] pix_t;  // {x, y, colour}
  pix_t wq[$];
  int   ds_cnt = 0;
  int   vectors = 0, miscompares = 0;

  always @(negedge clk) begin
    if (writeEn === 1'b1) wq.push_back({x_out, y_out, colour});
    if (draw_start === 1'b1) ds_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] slot_x(input int s);
    return 8'(8 + s * 40);
  endfunction

  function automatic int clear_bad(input int start);
    int bad = 0;
    for (int i = 0; i < 19200; i++) begin
      pix_t e = {8'(i % 160), 7'(i / 160), 3'b000};
      if (start + i >= wq.size() || wq[start + i] !== e) bad++;
    end
    return bad;
  endfunction

  function automatic int erase_bad(input int start, input logic [7:0] ox);
    int bad = 0;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 36; c++) begin
        pix_t e = {8'(ox + 8'(c)), 7'(20 + r), 3'b000};
        int idx = start + r * 36 + c;
        if (idx >= wq.size() || wq[idx] !== e) bad++;
      end
    return bad;
  endfunction

  task automatic wait_ready(input int bound);
    int n = 0;
    while (note_ready !== 1'b1 && n < bound) begin cyc(); n++; end
    chk("ready_wait", note_ready, 1);
  endtask

  task automatic wait_draw_start(input bit noisy);
    int n = 0;
    while (draw_start !== 1'b1 && n < 600) begin
      if (noisy) begin
        eng_we = 1'b1; eng_x = 8'($urandom); eng_y = 7'($urandom_range(0, 119));
        draw_done = (n == 100);
      end
      cyc(); n++;
    end
    eng_we = 1'b0; draw_done = 1'b0;
    chk("draw_start_seen", draw_start, 1);
  endtask

  task automatic run_event(input int note, input int oct, input int slot,
                           input bit clr_in_wait, input bit noisy);
    pix_t fwd[$];
    int   fb = 0, k;
    logic [7:0] ox = slot_x(slot);
    wq.delete(); ds_cnt = 0;
    chk("ready_before", note_ready, 1);
    note_valid = 1'b1; note_in = 4'(note); octave_in = 2'(oct); slot_in = 2'(slot);
    cyc();
    note_valid = 1'b0; note_in = 4'($urandom); octave_in = 2'($urandom); slot_in = 2'($urandom);
    chk("first_erase_we", writeEn, 1);
    chk("first_erase_xy", {x_out, y_out}, {ox, 7'd20});
    if (note != 0) begin
      wait_draw_start(noisy);
      chk("draw_x", draw_x, ox);
      chk("draw_y", draw_y, 20);
      chk("draw_note_oct", {draw_note, draw_octave}, {4'(note), 2'(oct)});
      chk("erase_cnt", wq.size(), 432);
      chk("erase_pix", erase_bad(0, ox), 0);
      k = $urandom_range(3, 10);
      for (int j = 0; j < k; j++) begin
        eng_we = 1'($urandom); eng_x = 8'($urandom);
        eng_y = 7'($urandom_range(0, 119)); eng_colour = 3'($urandom);
        if (eng_we) fwd.push_back({eng_x, eng_y, eng_colour});
        clr_req = clr_in_wait && (j == 1);
        cyc();
      end
      clr_req = 1'b0; eng_we = 1'b0;
      chk("draw_hold", {draw_start, draw_x, draw_y}, {1'b0, ox, 7'd20});
      draw_done = 1'b1;
      cyc();
      draw_done = 1'b0;
      chk("we_after_done", writeEn, 0);
      wait_ready(clr_in_wait ? 20500 : 50);
      chk("start_pulses", ds_cnt, 1);
      chk("total_writes", wq.size(), 432 + fwd.size() + (clr_in_wait ? 19200 : 0));
      foreach (fwd[i]) if (432 + i >= wq.size() || wq[432 + i] !== fwd[i]) fb++;
      chk("fwd_pix", fb, 0);
      if (clr_in_wait) chk("pend_clear_pix", clear_bad(432 + fwd.size()), 0);
    end else begin
      if (noisy) begin
        for (int j = 0; j < 40; j++) begin
          eng_we = 1'b1; eng_x = 8'($urandom); draw_done = (j == 20); cyc();
        end
        eng_we = 1'b0; draw_done = 1'b0;
      end
      wait_ready(600);
      chk("start_pulses0", ds_cnt, 0);
      chk("erase_cnt0", wq.size(), 432);
      chk("erase_pix0", erase_bad(0, ox), 0);
    end
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int s;
    #3 resetn = 1'b0;
    #1;
    chk("rst_we", writeEn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xy", {x_out, y_out, colour, draw_start}, 0);
    cyc(); cyc();
    wq.delete();
    resetn = 1'b1;
    wait_ready(20500);
    chk("init_clear_cnt", wq.size(), 19200);
    chk("init_clear_pix", clear_bad(0), 0);
    chk("init_busy", busy, 0);

    run_event(1, 0, 2, 1'b0, 1'b0);
    run_event(0, 1, 0, 1'b0, 1'b1);

    // Clear and note together: clear wins, note is taken right after.
    s = $urandom_range(0, 3);
    wq.delete();
    clr_req = 1'b1; note_valid = 1'b1; note_in = 4'd0; slot_in = 2'(s);
    #1 chk("clr_blocks_ready", note_ready, 0);
    cyc();
    clr_req = 1'b0;
    wait_ready(20500);
    cyc();
    note_valid = 1'b0;
    chk("post_clear_accept", {writeEn, x_out}, {1'b1, slot_x(s)});
    wait_ready(600);
    chk("clr_note_cnt", wq.size(), 19200 + 432);
    chk("clr_note_clear", clear_bad(0), 0);
    chk("clr_note_erase", erase_bad(19200, slot_x(s)), 0);

    run_event($urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      run_event($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'($urandom));

    // Reset in the middle of an erase.
    note_valid = 1'b1; note_in = 4'd5; slot_in = 2'd3;
    cyc();
    note_valid = 1'b0;
    repeat (100) cyc();
    resetn = 1'b0;
    #1;
    chk("midrst_we", writeEn, 0);
    chk("midrst_out", {busy, x_out, y_out}, 0);
    cyc(); cyc();
    wq.delete();
    resetn = 1'b1;
    wait_ready(20500);
    chk("midrst_clear_cnt", wq.size(), 19200);
    chk("midrst_clear_pix", clear_bad(0), 0);

`ifdef VGA_NOTE_SCHED_TIMEOUT_EN
    note_valid = 1'b1; note_in = 4'd3; slot_in = 2'd1;
    cyc();
    note_valid = 1'b0;
    wait_draw_start(1'b0);
    wait_ready(1100);
    chk("timeout_flag", draw_timeout, 1);
    run_event(0, 0, 1, 1'b0, 1'b0);
    chk("timeout_cleared", draw_timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
